// File: rtl/adder_pkg.sv
// Width helpers shared by the pipelined adder tree and its per-level stage.
// The derived widths W, L and OW are computed here so the top module and the bench agree on them.
package adder_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Lane width: significand plus sign/carry/hidden headroom plus low guard bits.
  function automatic int calc_w(input int sig_width, input int low_expand);
    return sig_width + 4 + low_expand;
  endfunction

  function automatic int calc_ow(input int sig_width, input int low_expand,
                                 input int num_in, input int acc_ext);
    return calc_w(sig_width, low_expand) + clog2(num_in) + acc_ext;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One level of the adder tree: pairwise sign-extended sums of N lanes, registered
// together with the valid/acc/last sideband bits. The stage holds while en is low.
module adder_tree_stage
  import adder_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic                      in_acc,
  input  logic                      in_last,
  input  logic [N*IW-1:0]           in_data,
  output logic                      out_valid,
  output logic                      out_acc,
  output logic                      out_last,
  output logic [(N/2)*(IW+1)-1:0]   out_data
);

  localparam int NO = N / 2;
  localparam int SW = IW + 1;

  logic [NO*SW-1:0] sum;

  // NOTE: always_comb assigns a default first so no path leaves sum unassigned (no latch).
  always_comb begin
    sum = '0;
    for (int i = 0; i < NO; i++) begin
      sum[i*SW +: SW] = {in_data[(2*i)*IW + IW - 1],   in_data[(2*i)*IW +: IW]}
                      + {in_data[(2*i+1)*IW + IW - 1], in_data[(2*i+1)*IW +: IW]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_acc   <= in_acc;
      out_last  <= in_last;
    end
  end

  // NOTE: data registers carry no reset; out_valid qualifies them, so their power-up value is never used.
  always_ff @(posedge clk) begin
    if (en) out_data <= sum;
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree over NUM_IN lanes followed by a group accumulator
// with wrap-around arithmetic and a sticky overflow flag; whole pipe stalls on backpressure.
module adder_tree_pipe
  import adder_pkg::*;
#(
  parameter int SIG_WIDTH  = 4,
  parameter int LOW_EXPAND = 2,
  parameter int NUM_IN     = 4,
  parameter int ACC_EXT    = 4,
  localparam int W  = calc_w(SIG_WIDTH, LOW_EXPAND),
  localparam int L  = clog2(NUM_IN),
  localparam int OW = calc_ow(SIG_WIDTH, LOW_EXPAND, NUM_IN, ACC_EXT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_IN*W-1:0] in_data,
  input  logic                in_acc,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OW-1:0]       out_data,
  output logic                out_ovf
);

  logic vld  [L+1];
  logic acc  [L+1];
  logic last [L+1];

  assign in_ready = out_ready || !out_valid;
  assign vld[0]   = in_valid;
  assign acc[0]   = in_acc;
  assign last[0]  = in_last;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int NI = NUM_IN >> k;
    localparam int IW = W + k;
    logic [NI*IW-1:0]           d_in;
    logic [(NI/2)*(IW+1)-1:0]   d_out;

    if (k == 0) begin : g_first
      assign d_in = in_data;
    end else begin : g_next
      assign d_in = g_lvl[k-1].d_out;
    end

    adder_tree_stage #(.N(NI), .IW(IW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (in_ready),
      .in_valid  (vld[k]),
      .in_acc    (acc[k]),
      .in_last   (last[k]),
      .in_data   (d_in),
      .out_valid (vld[k+1]),
      .out_acc   (acc[k+1]),
      .out_last  (last[k+1]),
      .out_data  (d_out)
    );
  end

  logic [W+L-1:0] tree_sum;
  logic [OW-1:0]  sum_ext;
  logic [OW-1:0]  acc_q;
  logic [OW-1:0]  base;
  logic [OW-1:0]  total;
  logic           grp_open;
  logic           sticky_ovf;
  logic           closing;
  logic           ovf_now;

  assign tree_sum = g_lvl[L-1].d_out;
  assign sum_ext  = OW'($signed(tree_sum));

  // A standalone beat while a group is open closes that group.
  assign closing = !acc[L] || last[L];
  assign base    = grp_open ? acc_q : '0;
  assign total   = base + sum_ext;
  assign ovf_now = (base[OW-1] == sum_ext[OW-1]) && (total[OW-1] != base[OW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      acc_q      <= '0;
      grp_open   <= 1'b0;
      sticky_ovf <= 1'b0;
    end else if (in_ready) begin
      out_valid <= 1'b0;
      if (vld[L]) begin
        if (closing) begin
          out_valid  <= 1'b1;
          out_data   <= total;
          out_ovf    <= (grp_open && sticky_ovf) || ovf_now;
          acc_q      <= '0;
          grp_open   <= 1'b0;
          sticky_ovf <= 1'b0;
        end else begin
          acc_q      <= total;
          grp_open   <= 1'b1;
          sticky_ovf <= (grp_open && sticky_ovf) || ovf_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe at default parameters (W=10, OW=16, latency 3):
// the driver queues hand-computed results, an independent monitor pops and compares them.
module tb_adder_tree_pipe;

  localparam int W  = 10;
  localparam int OW = 16;

  typedef struct {
    logic [OW-1:0] data;
    logic          ovf;
    int            cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4*W-1:0]  in_data;
  logic            in_acc;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;
  logic            out_ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  adder_tree_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Presents one beat and holds it until accepted; pushes the expected result if the beat emits one.
  task automatic send(input logic [W-1:0] l0, input logic [W-1:0] l1,
                      input logic [W-1:0] l2, input logic [W-1:0] l3,
                      input logic a, input logic lst,
                      input bit has_out, input logic [OW-1:0] exp_data,
                      input logic exp_ovf, input bit chk_lat);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {l3, l2, l1, l0};
    in_acc   = a;
    in_last  = lst;
    #2;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 100) check("in_ready_timeout", 32'd0, 32'd1);
    if (has_out) begin
      e.data = exp_data;
      e.ovf  = exp_ovf;
      e.cyc  = chk_lat ? cyc + 3 : -1;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever a result transfers.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", {16'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("out_data", {16'h0, out_data}, {16'h0, e.data});
          check("out_ovf", {31'h0, out_ovf}, {31'h0, e.ovf});
          if (e.cyc >= 0) check("latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  logic [OW-1:0] bp_exp [6] = '{16'd2, 16'd5, 16'd8, 16'd11, 16'd14, 16'd17};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_acc    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data",  {16'h0, out_data},  32'd0);
    check("rst_out_ovf",   {31'h0, out_ovf},   32'd0);
    check("rst_in_ready",  {31'h0, in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Standalone beats: latency, sign handling and range limits.
    send(10'd1, 10'd2, 10'd3, 10'd4, 1'b0, 1'b0, 1, 16'd10, 1'b0, 1);
    wait_drain();
    send(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1, 16'hFFFC, 1'b0, 0);
    send(10'd511, 10'h200, 10'd7, 10'h3FD, 1'b0, 1'b0, 1, 16'd3, 1'b0, 0);
    send(10'd511, 10'd511, 10'd511, 10'd511, 1'b0, 1'b0, 1, 16'h07FC, 1'b0, 0);
    send(10'h200, 10'h200, 10'h200, 10'h200, 1'b0, 1'b0, 1, 16'hF800, 1'b0, 0);

    // Three-beat group; no output until the closing beat.
    send(10'd100, 10'd100, 10'd100, 10'd100, 1'b1, 1'b0, 0, '0, 1'b0, 0);
    send(10'd100, 10'd100, 10'd100, 10'd100, 1'b1, 1'b0, 0, '0, 1'b0, 0);
    send(10'd100, 10'd100, 10'd100, 10'd100, 1'b1, 1'b1, 1, 16'd1200, 1'b0, 0);

    // Single-beat group, then a standalone beat closing an open group.
    send(10'd5, 10'd5, 10'd5, 10'd5, 1'b1, 1'b1, 1, 16'd20, 1'b0, 0);
    send(10'd10, 10'd10, 10'd10, 10'd10, 1'b1, 1'b0, 0, '0, 1'b0, 0);
    send(10'd1, 10'd2, 10'd3, 10'd4, 1'b0, 1'b0, 1, 16'd50, 1'b0, 0);
    wait_drain();

    // Backpressure: 6 beats of sums 3i-1 with out_ready low for 5 cycles.
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(W'(i), W'(2*i), 10'h3FF, 10'd0, 1'b0, 1'b0, 1, bp_exp[i-1], 1'b0, 0);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) begin
          #3;
          if (out_valid) check("stall_in_ready", {31'h0, in_ready}, 32'd0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Overflow: 20 beats of 2044 wrap to 0x9FB0; the sticky flag clears afterwards.
    for (int i = 1; i <= 20; i++)
      send(10'd511, 10'd511, 10'd511, 10'd511, 1'b1, (i == 20), (i == 20), 16'h9FB0, 1'b1, 0);
    send(10'd1, 10'd2, 10'd3, 10'd4, 1'b0, 1'b0, 1, 16'd10, 1'b0, 0);
    wait_drain();

    // Reset in the middle of a group discards it.
    send(10'd7, 10'd7, 10'd7, 10'd7, 1'b1, 1'b0, 0, '0, 1'b0, 0);
    send(10'd7, 10'd7, 10'd7, 10'd7, 1'b1, 1'b0, 0, '0, 1'b0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    check("midrst_in_ready",  {31'h0, in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(10'd1, 10'd1, 10'd1, 10'd1, 1'b0, 1'b0, 1, 16'd4, 1'b0, 1);
    wait_drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
